// File: rtl/frame_stats.sv
// Frame statistics engine: claims a full ping-pong buffer, streams its samples,
// and reports peak magnitude, sum of squares, sample count and a length-error flag.
module frame_stats #(
    parameter int SAMPLE_W = 16,
    parameter int BUF_LEN  = 256,
    parameter int ACC_W    = 40
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      buf_ready_i,
    input  logic                      buf_id_i,
    output logic                      buf_take_o,
    input  logic [SAMPLE_W-1:0]       rd_data_i,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    input  logic                      rd_last_i,
    output logic                      stats_valid_o,
    input  logic                      stats_ready_i,
    output logic [SAMPLE_W-1:0]       peak_o,
    output logic [ACC_W-1:0]          sum_sq_o,
    output logic [$clog2(BUF_LEN):0]  count_o,
    output logic                      frame_id_o,
    output logic                      len_err_o
);

    localparam int CNT_W = $clog2(BUF_LEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAKE,
        S_READ,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [SAMPLE_W-1:0]   r_peak;
    logic [ACC_W-1:0]      r_sum;
    logic [CNT_W-1:0]      r_count;
    logic                  r_frame_id;
    logic                  r_len_err;

    logic                  w_start;
    logic                  w_xfer;
    logic [SAMPLE_W-1:0]   w_abs;
    logic [SAMPLE_W-1:0]   w_peak_next;
    logic [2*SAMPLE_W-1:0] w_sq;
    logic [ACC_W-1:0]      w_sq_ext;
    logic [CNT_W-1:0]      w_count_inc;
    logic                  w_at_len;
    logic                  w_frame_end;

    assign w_start = (r_state == S_IDLE) && buf_ready_i;
    assign w_xfer  = (r_state == S_READ) && rd_valid_i;

    // Two's-complement negate in SAMPLE_W bits: the most negative value maps to
    // 2^(SAMPLE_W-1) when read as unsigned, which is exactly its magnitude.
    assign w_abs       = rd_data_i[SAMPLE_W-1] ? (~rd_data_i + 1'b1) : rd_data_i;
    assign w_peak_next = (w_abs > r_peak) ? w_abs : r_peak;
    assign w_sq        = {{SAMPLE_W{1'b0}}, w_abs} * {{SAMPLE_W{1'b0}}, w_abs};

    generate
        if (ACC_W > 2*SAMPLE_W) begin : g_sq_pad
            assign w_sq_ext = {{(ACC_W-2*SAMPLE_W){1'b0}}, w_sq};
        end else begin : g_sq_trunc
            assign w_sq_ext = w_sq[ACC_W-1:0];
        end
    endgenerate

    assign w_count_inc = r_count + 1'b1;
    assign w_at_len    = (w_count_inc == CNT_W'(BUF_LEN));
    assign w_frame_end = w_xfer && (rd_last_i || w_at_len);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        buf_take_o    = 1'b0;
        rd_ready_o    = 1'b0;
        stats_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (buf_ready_i) begin
                    w_state_next = S_TAKE;
                end
            end
            S_TAKE: begin
                buf_take_o   = 1'b1;
                w_state_next = S_READ;
            end
            S_READ: begin
                rd_ready_o = 1'b1;
                if (w_frame_end) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                stats_valid_o = 1'b1;
                if (stats_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Results are cleared only when a new buffer is claimed, so the last frame
    // stays visible after the consumer has accepted it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_peak     <= '0;
            r_sum      <= '0;
            r_count    <= '0;
            r_frame_id <= 1'b0;
            r_len_err  <= 1'b0;
        end else if (w_start) begin
            r_peak     <= '0;
            r_sum      <= '0;
            r_count    <= '0;
            r_frame_id <= buf_id_i;
            r_len_err  <= 1'b0;
        end else if (w_xfer) begin
            r_peak  <= w_peak_next;
            r_sum   <= r_sum + w_sq_ext;
            r_count <= w_count_inc;
            if (rd_last_i) begin
                r_len_err <= !w_at_len;
            end else if (w_at_len) begin
                r_len_err <= 1'b1;
            end
        end
    end

    assign peak_o     = r_peak;
    assign sum_sq_o   = r_sum;
    assign count_o    = r_count;
    assign frame_id_o = r_frame_id;
    assign len_err_o  = r_len_err;

endmodule

// File: tb/tb_frame_stats.sv
// Directed bench for frame_stats: a frame-level model predicts the reported
// statistics, and a per-cycle compare process checks them whenever they are valid or held.
module tb_frame_stats;

    localparam int SW = 16;
    localparam int BL = 256;
    localparam int AW = 40;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          buf_ready_i = 1'b0;
    logic          buf_id_i = 1'b0;
    logic          buf_take_o;
    logic [SW-1:0] rd_data_i = '0;
    logic          rd_valid_i = 1'b0;
    logic          rd_ready_o;
    logic          rd_last_i = 1'b0;
    logic          stats_valid_o;
    logic          stats_ready_i = 1'b0;
    logic [SW-1:0] peak_o;
    logic [AW-1:0] sum_sq_o;
    logic [8:0]    count_o;
    logic          frame_id_o;
    logic          len_err_o;

    frame_stats #(.SAMPLE_W(SW), .BUF_LEN(BL), .ACC_W(AW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .buf_ready_i   (buf_ready_i),
        .buf_id_i      (buf_id_i),
        .buf_take_o    (buf_take_o),
        .rd_data_i     (rd_data_i),
        .rd_valid_i    (rd_valid_i),
        .rd_ready_o    (rd_ready_o),
        .rd_last_i     (rd_last_i),
        .stats_valid_o (stats_valid_o),
        .stats_ready_i (stats_ready_i),
        .peak_o        (peak_o),
        .sum_sq_o      (sum_sq_o),
        .count_o       (count_o),
        .frame_id_o    (frame_id_o),
        .len_err_o     (len_err_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [SW-1:0] tb_data [0:299];

    logic [SW-1:0] exp_peak = '0;
    logic [AW-1:0] exp_sum = '0;
    logic [8:0]    exp_count = '0;
    logic          exp_id = 1'b0;
    logic          exp_len_err = 1'b0;
    bit            exp_armed = 1'b0;
    bit            hold_mode = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Frame-level model: which samples count, and what the statistics of them are.
    task automatic model(input bit id, input int last_idx);
        int     n;
        int     v;
        int     a;
        int     pk;
        longint s;
        n  = (last_idx >= 0) ? last_idx + 1 : BL;
        pk = 0;
        s  = 0;
        for (int k = 0; k < n; k++) begin
            v = int'($signed(tb_data[k]));
            a = (v < 0) ? -v : v;
            if (a > pk) pk = a;
            s += longint'(a) * longint'(a);
        end
        exp_peak    = pk[SW-1:0];
        exp_sum     = s[AW-1:0];
        exp_count   = n[8:0];
        exp_id      = id;
        exp_len_err = (last_idx < 0) || (n != BL);
    endtask

    task automatic zero_expect();
        exp_peak    = '0;
        exp_sum     = '0;
        exp_count   = '0;
        exp_id      = 1'b0;
        exp_len_err = 1'b0;
        exp_armed   = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (stats_valid_o) begin
            if (!exp_armed) begin
                check("unexpected_valid", 64'(stats_valid_o), 64'd0);
            end else begin
                check("valid_peak", 64'(peak_o), 64'(exp_peak));
                check("valid_sum", 64'(sum_sq_o), 64'(exp_sum));
                check("valid_count", 64'(count_o), 64'(exp_count));
                check("valid_id", 64'(frame_id_o), 64'(exp_id));
                check("valid_len_err", 64'(len_err_o), 64'(exp_len_err));
            end
        end else if (hold_mode) begin
            check("hold_peak", 64'(peak_o), 64'(exp_peak));
            check("hold_sum", 64'(sum_sq_o), 64'(exp_sum));
            check("hold_count", 64'(count_o), 64'(exp_count));
            check("hold_id", 64'(frame_id_o), 64'(exp_id));
            check("hold_len_err", 64'(len_err_o), 64'(exp_len_err));
        end
        check("ctrl_onehot", 64'($countones({buf_take_o, rd_ready_o, stats_valid_o}) <= 1), 64'd1);
    end

    task automatic run_frame(input bit id, input int last_idx, input int n_send, input int gap_max,
                             input int hold_cycles, input bit keep_ready, input int abort_at);
        int n_acc;
        int k;
        int g;
        int wait_n;
        n_acc = (last_idx >= 0) ? last_idx + 1 : BL;
        @(negedge clk_i); #1;
        hold_mode = 1'b0;
        if (abort_at < 0) begin
            model(id, last_idx);
            exp_armed = 1'b1;
        end else begin
            exp_armed = 1'b0;
        end
        buf_ready_i = 1'b1;
        buf_id_i    = id;
        @(negedge clk_i); #1;
        check("take_pulse", 64'(buf_take_o), 64'd1);
        check("take_no_ready", 64'(rd_ready_o), 64'd0);
        buf_id_i = ~id;
        if (!keep_ready) buf_ready_i = 1'b0;
        @(negedge clk_i); #1;
        check("take_single", 64'(buf_take_o), 64'd0);
        check("read_latency", 64'(rd_ready_o), 64'd1);
        k = 0;
        while (k < n_acc) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            rd_valid_i = 1'b0;
            repeat (g) begin
                @(negedge clk_i); #1;
            end
            rd_valid_i = 1'b1;
            rd_data_i  = tb_data[k];
            rd_last_i  = (k == last_idx);
            wait_n = 0;
            while (rd_ready_o !== 1'b1 && wait_n < 50) begin
                @(negedge clk_i); #1;
                wait_n++;
            end
            if (rd_ready_o !== 1'b1) begin
                check("accept_timeout", 64'(k), 64'(n_acc));
                break;
            end
            @(negedge clk_i); #1;
            k++;
            if (abort_at >= 0 && k == abort_at) begin
                rd_valid_i = 1'b0;
                rd_last_i  = 1'b0;
                check("mid_count", 64'(count_o), 64'(abort_at));
                rst_ni = 1'b0;
                #1;
                check("rst_take", 64'(buf_take_o), 64'd0);
                check("rst_ready", 64'(rd_ready_o), 64'd0);
                check("rst_valid", 64'(stats_valid_o), 64'd0);
                check("rst_peak", 64'(peak_o), 64'd0);
                check("rst_sum", 64'(sum_sq_o), 64'd0);
                check("rst_count", 64'(count_o), 64'd0);
                check("rst_len_err", 64'(len_err_o), 64'd0);
                zero_expect();
                hold_mode   = 1'b1;
                buf_ready_i = 1'b0;
                @(negedge clk_i); #1;
                rst_ni = 1'b1;
                $display("frame aborted by reset after %0d transfers", abort_at);
                return;
            end
        end
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;
        check("done_latency", 64'(stats_valid_o), 64'd1);
        check("ready_drop", 64'(rd_ready_o), 64'd0);
        if (n_send > n_acc) begin
            rd_valid_i = 1'b1;
            rd_data_i  = tb_data[n_acc];
            repeat (3) begin
                check("no_extra_accept", 64'(rd_ready_o), 64'd0);
                @(negedge clk_i); #1;
            end
            rd_valid_i = 1'b0;
        end
        for (int h = 0; h < hold_cycles; h++) begin
            check("hold_valid", 64'(stats_valid_o), 64'd1);
            check("hold_no_take", 64'(buf_take_o), 64'd0);
            @(negedge clk_i); #1;
        end
        stats_ready_i = 1'b1;
        buf_ready_i   = 1'b0;
        @(negedge clk_i); #1;
        check("valid_drop", 64'(stats_valid_o), 64'd0);
        stats_ready_i = 1'b0;
        hold_mode     = 1'b1;
        $display("frame id=%0d count=%0d peak=%0h sum=%0h len_err=%0d",
                 frame_id_o, count_o, peak_o, sum_sq_o, len_err_o);
        repeat (3) @(negedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_take", 64'(buf_take_o), 64'd0);
        check("reset_ready", 64'(rd_ready_o), 64'd0);
        check("reset_valid", 64'(stats_valid_o), 64'd0);
        check("reset_count", 64'(count_o), 64'd0);
        rst_ni = 1'b1;

        // Ramp 0x1000..0x10FF, proper last
        for (int i = 0; i < 256; i++) tb_data[i] = 16'h1000 + 16'(i);
        run_frame(1'b0, 255, 256, 0, 2, 1'b0, -1);
        check("A_peak", 64'(peak_o), 64'h10FF);
        check("A_sum", 64'(sum_sq_o), 64'd4567913856);
        check("A_count", 64'(count_o), 64'd256);
        check("A_len_err", 64'(len_err_o), 64'd0);

        // Full-scale negative samples
        for (int i = 0; i < 256; i++) tb_data[i] = 16'h8000;
        run_frame(1'b0, 255, 256, 1, 0, 1'b0, -1);
        check("B_peak", 64'(peak_o), 64'h8000);
        check("B_sum", 64'(sum_sq_o), 64'h40_0000_0000);
        check("B_len_err", 64'(len_err_o), 64'd0);

        // Short frame: last on the 100th sample
        for (int i = 0; i < 256; i++) tb_data[i] = 16'(i * 7 - 300);
        run_frame(1'b0, 99, 100, 2, 1, 1'b0, -1);
        check("C_count", 64'(count_o), 64'd100);
        check("C_peak", 64'(peak_o), 64'd393);
        check("C_len_err", 64'(len_err_o), 64'd1);

        // Missing last, 257th offered, long stall with buf_ready held high
        for (int i = 0; i < 300; i++) tb_data[i] = 16'($urandom);
        run_frame(1'b1, -1, 257, 0, 20, 1'b1, -1);
        check("D_count", 64'(count_o), 64'd256);
        check("D_len_err", 64'(len_err_o), 64'd1);
        check("D_frame_id", 64'(frame_id_o), 64'd1);

        // Reset in the middle of a gappy frame, then a full clean frame
        for (int i = 0; i < 256; i++) tb_data[i] = 16'($urandom);
        run_frame(1'b1, 255, 256, 3, 0, 1'b0, 50);
        for (int i = 0; i < 256; i++) tb_data[i] = 16'($urandom);
        run_frame(1'b0, 255, 256, 3, 3, 1'b0, -1);
        check("F_count", 64'(count_o), 64'd256);
        check("F_len_err", 64'(len_err_o), 64'd0);
        check("F_frame_id", 64'(frame_id_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
